pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Merges the load-use stall request from the hazard detector, the EX-stage branch/jump redirect, the data-memory ready handshake and the halt/resume control.
- Drives per-stage register enables, flushes and the PC-source select.
- Owns a memory-wait watchdog and a saturating stall-cycle counter.

Parameters:
- WIDTH, 32, width of stall_cnt_out.
- TIMEOUT, 16, maximum MEM_WAIT cycles before FAULT (must be >= 2).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- ifid_stall_req_in  input  1  load-use stall request from hazard detector.
- ex_redirect_in  input  1  taken branch/jump resolved in EX.
- exmem_mem_req_in  input  1  instruction in MEM performs a load/store.
- dmem_ready_in  input  1  data memory completes the access this cycle.
- halt_in  input  1  ecall/ebreak present in WB.
- resume_in  input  1  debug resume pulse.
- pc_en_out  output  1  PC register enable.
- pc_sel_out  output  1  1 selects the redirect target, 0 selects PC+4.
- ifid_en_out  output  1  IF/ID enable.
- ifid_flush_out  output  1  IF/ID load bubble.
- idex_en_out  output  1  ID/EX enable.
- idex_flush_out  output  1  ID/EX load bubble.
- exmem_en_out  output  1  EX/MEM enable.
- memwb_en_out  output  1  MEM/WB enable.
- halted_out  output  1  state is HALT.
- fault_out  output  1  state is FAULT (sticky).
- state_out  output  2  RUN=0, MEM_WAIT=1, HALT=2, FAULT=3.
- stall_cnt_out  output  WIDTH  saturating count of stalled cycles.

Behaviour:
- Registered state: FSM state, wait_cnt (ceil(log2 TIMEOUT) bits), stall_cnt. All other outputs are combinational from state and inputs (Mealy), so they act in the same cycle.
- Reset (async): state=RUN, wait_cnt=0, stall_cnt=0.
  - While rst_in=1: all enables, flushes, pc_sel, halted and fault are 0.
  - Reset asserted mid-wait or in FAULT/HALT returns the block to RUN.
- FREEZE pattern: all *_en=0, all flushes=0, pc_sel=0.
- NORMAL pattern: all *_en=1, flushes=0, pc_sel=0.
- RUN, evaluated in this priority order:
  1. exmem_mem_req_in & !dmem_ready_in: FREEZE; next state MEM_WAIT; wait_cnt<=0.
  2. halt_in: FREEZE; next state HALT.
  3. ex_redirect_in: NORMAL, plus pc_sel=1, ifid_flush=1, idex_flush=1. Any simultaneous load-use request is discarded because it belongs to the wrong path.
  4. ifid_stall_req_in: pc_en=0, ifid_en=0, idex_flush=1; exmem/memwb enables stay 1.
  5. Otherwise NORMAL.
- MEM_WAIT:
  - dmem_ready_in=1: evaluate exactly as RUN rules 2-5, which lets a redirect or load-use held by the frozen pipe take effect now; next state is RUN unless rule 2 selects HALT.
  - dmem_ready_in=0 and wait_cnt==TIMEOUT-1: FREEZE; next state FAULT.
  - Otherwise: FREEZE; wait_cnt++.
  - Ready in the timeout cycle wins over FAULT.
- HALT:
  - FREEZE with halted_out=1.
  - resume_in=1: NORMAL this cycle so the halting instruction retires; next state RUN. halt_in is ignored in HALT.
- FAULT: FREEZE with fault_out=1 until reset; all inputs are ignored.
- stall_cnt increments on every cycle where pc_en_out=0 and state is RUN or MEM_WAIT. It saturates at 2^WIDTH-1 and never wraps.
- state_out reflects the registered state.

Test Plan:
- Reset then idle, no requests for 10 cycles -> all enables 1, flushes 0, state_out=0, stall_cnt_out=0.
- ifid_stall_req_in=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt_out=1 next cycle.
- ex_redirect_in=1 and ifid_stall_req_in=1 in the same cycle -> pc_sel=1, ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt_out unchanged.
- mem_req=1, dmem_ready=0 for 3 cycles, then ready=1 with ex_redirect_in=1:
  - 3 FREEZE cycles with state 0,1,1.
  - 4th cycle applies the redirect pattern; state returns to 0.
  - stall_cnt_out=3.
- TIMEOUT=4, mem_req=1, dmem_ready held 0 -> FREEZE in RUN plus 4 MEM_WAIT cycles, then state_out=3 and fault_out=1. ready=1 afterwards has no effect; rst_in pulse -> state 0, fault 0.
- Halt sequence and saturation:
  - halt_in=1 -> halted_out=1 next cycle; resume_in=1 -> NORMAL that cycle, state 0 next cycle.
  - WIDTH=3 with 9 load-use cycles -> stall_cnt_out stops at 7.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Stall/flush scheduler for the five-stage RV32 pipeline (IF, ID, EX, MEM,
// WB). It merges the load-use stall request, the EX-stage redirect, the data
// memory ready handshake and the halt/resume control into per-stage register
// enables, bubble flushes and the PC source select. It also runs a watchdog
// on outstanding data-memory accesses and a saturating count of stalled
// cycles.
//
// Parameters
//   WIDTH    width of the stall-cycle counter
//   TIMEOUT  MEM_WAIT cycles tolerated before the block faults (>= 2)
//
// Ports
//   clk_in             clock, rising edge
//   rst_in             asynchronous active-high reset
//   ifid_stall_req_in  load-use stall request from the hazard detector
//   ex_redirect_in     taken branch/jump resolved in EX
//   exmem_mem_req_in   instruction in MEM performs a load/store
//   dmem_ready_in      data memory completes the access this cycle
//   halt_in            ecall/ebreak present in WB
//   resume_in          debug resume pulse
//   pc_en_out          PC register enable
//   pc_sel_out         1 = redirect target, 0 = PC+4
//   ifid_en_out        IF/ID enable
//   ifid_flush_out     IF/ID loads a bubble
//   idex_en_out        ID/EX enable
//   idex_flush_out     ID/EX loads a bubble
//   exmem_en_out       EX/MEM enable
//   memwb_en_out       MEM/WB enable
//   halted_out         block is in HALT
//   fault_out          block is in FAULT (sticky until reset)
//   state_out          registered state: RUN=0, MEM_WAIT=1, HALT=2, FAULT=3
//   stall_cnt_out      saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             ifid_stall_req_in,
   input  logic             ex_redirect_in,
   input  logic             exmem_mem_req_in,
   input  logic             dmem_ready_in,
   input  logic             halt_in,
   input  logic             resume_in,
   output logic             pc_en_out,
   output logic             pc_sel_out,
   output logic             ifid_en_out,
   output logic             ifid_flush_out,
   output logic             idex_en_out,
   output logic             idex_flush_out,
   output logic             exmem_en_out,
   output logic             memwb_en_out,
   output logic             halted_out,
   output logic             fault_out,
   output logic [1:0]       state_out,
   output logic [WIDTH-1:0] stall_cnt_out
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2,
      FAULT    = 2'd3
   } state_t;

   // Pipeline control patterns the output decoder can select between.
   typedef enum logic [1:0] {
      PAT_FREEZE   = 2'd0,
      PAT_NORMAL   = 2'd1,
      PAT_REDIRECT = 2'd2,
      PAT_LOADUSE  = 2'd3
   } pattern_t;

   localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0]  STALL_MAX = '1;

   state_t            state_q;
   state_t            state_d;
   logic [WAIT_W-1:0] waitCnt_q;
   logic [WAIT_W-1:0] waitCnt_d;
   logic [WIDTH-1:0]  stallCnt_q;
   logic [WIDTH-1:0]  stallCnt_d;

   logic              memMiss;
   pattern_t          issuePat;
   pattern_t          pattern;
   logic              pcEn;

   assign memMiss = exmem_mem_req_in & ~dmem_ready_in;

   // Pattern chosen once the memory stage is known to be able to advance.
   // Halt outranks the redirect, which outranks the load-use stall; a
   // load-use request seen together with a redirect comes from a wrong-path
   // instruction and is simply dropped. MEM_WAIT reuses this on the cycle
   // the memory answers, so hazards held by the frozen pipe act right away.
   always_comb begin
      issuePat = PAT_NORMAL;
      if (halt_in) begin
         issuePat = PAT_FREEZE;
      end else if (ex_redirect_in) begin
         issuePat = PAT_REDIRECT;
      end else if (ifid_stall_req_in) begin
         issuePat = PAT_LOADUSE;
      end
   end

   // State register: FSM state, watchdog count and stall count. Reset
   // returns everything to RUN from any state, including FAULT.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   // Next-state logic. The watchdog is cleared when a miss first appears in
   // RUN and advances once per unanswered MEM_WAIT cycle; a ready in the
   // last allowed cycle still completes normally instead of faulting.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      unique case (state_q)
         RUN: begin
            if (memMiss) begin
               state_d   = MEM_WAIT;
               waitCnt_d = '0;
            end else if (halt_in) begin
               state_d = HALT;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready_in) begin
               state_d = halt_in ? HALT : RUN;
            end else if (waitCnt_q == WAIT_LAST) begin
               state_d = FAULT;
            end else begin
               waitCnt_d = waitCnt_q + WAIT_W'(1);
            end
         end
         HALT: begin
            if (resume_in) begin
               state_d = RUN;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Output pattern selection (Mealy): depends on the registered state and
   // the current inputs so stalls and flushes act in the same cycle. A
   // resume lets the halting instruction retire on that very cycle.
   always_comb begin
      pattern = PAT_FREEZE;
      unique case (state_q)
         RUN: begin
            pattern = memMiss ? PAT_FREEZE : issuePat;
         end
         MEM_WAIT: begin
            pattern = dmem_ready_in ? issuePat : PAT_FREEZE;
         end
         HALT: begin
            pattern = resume_in ? PAT_NORMAL : PAT_FREEZE;
         end
         default: begin
            pattern = PAT_FREEZE;
         end
      endcase
   end

   // Pattern decode. While reset is held every control output is forced
   // low so the pipeline registers stay put until the scheduler is live.
   always_comb begin
      pcEn           = 1'b0;
      pc_sel_out     = 1'b0;
      ifid_en_out    = 1'b0;
      ifid_flush_out = 1'b0;
      idex_en_out    = 1'b0;
      idex_flush_out = 1'b0;
      exmem_en_out   = 1'b0;
      memwb_en_out   = 1'b0;
      if (!rst_in) begin
         unique case (pattern)
            PAT_NORMAL: begin
               pcEn         = 1'b1;
               ifid_en_out  = 1'b1;
               idex_en_out  = 1'b1;
               exmem_en_out = 1'b1;
               memwb_en_out = 1'b1;
            end
            PAT_REDIRECT: begin
               pcEn           = 1'b1;
               pc_sel_out     = 1'b1;
               ifid_en_out    = 1'b1;
               ifid_flush_out = 1'b1;
               idex_en_out    = 1'b1;
               idex_flush_out = 1'b1;
               exmem_en_out   = 1'b1;
               memwb_en_out   = 1'b1;
            end
            PAT_LOADUSE: begin
               // Hold PC and IF/ID, inject a bubble into ID/EX, let the
               // older instructions drain.
               idex_en_out    = 1'b1;
               idex_flush_out = 1'b1;
               exmem_en_out   = 1'b1;
               memwb_en_out   = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Stall counter: counts cycles where the PC is held while the pipeline
   // is live (RUN or MEM_WAIT); halted or faulted cycles are not stalls.
   // It saturates rather than wrapping.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (((state_q == RUN) || (state_q == MEM_WAIT)) && !pcEn
          && (stallCnt_q != STALL_MAX)) begin
         stallCnt_d = stallCnt_q + WIDTH'(1);
      end
   end

   assign pc_en_out     = pcEn;
   assign halted_out    = (state_q == HALT) & ~rst_in;
   assign fault_out     = (state_q == FAULT) & ~rst_in;
   assign state_out     = state_q;
   assign stall_cnt_out = stallCnt_q;

endmodule
